// File: rtl/cache_arbiter_if.sv
// Cache/bus handshake bundle: the arbiter owns the master view, the caches and the slave own the slave view.
interface cache_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   // instruction cache side
   logic          inst_cache_req;
   logic [AW-1:0] inst_cache_addr;
   logic [DW-1:0] inst_cache_rdata;
   logic          inst_cache_dok;

   // data cache side
   logic          data_cache_req;
   logic          data_cache_wr;
   logic [SW-1:0] data_cache_wstrb;
   logic [AW-1:0] data_cache_addr;
   logic [DW-1:0] data_cache_wdata;
   logic [DW-1:0] data_cache_rdata;
   logic          data_cache_dok;

   // downstream bus
   logic          bus_req;
   logic          bus_wr;
   logic [SW-1:0] bus_wstrb;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_addr_ok;
   logic          bus_data_ok;
   logic [DW-1:0] bus_rdata;

   modport master (
      input  inst_cache_req, inst_cache_addr,
      input  data_cache_req, data_cache_wr, data_cache_wstrb, data_cache_addr, data_cache_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata,
      output inst_cache_rdata, inst_cache_dok, data_cache_rdata, data_cache_dok,
      output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
   );

   modport slave (
      output inst_cache_req, inst_cache_addr,
      output data_cache_req, data_cache_wr, data_cache_wstrb, data_cache_addr, data_cache_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata,
      input  inst_cache_rdata, inst_cache_dok, data_cache_rdata, data_cache_dok,
      input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester cache arbiter: instruction and data caches share one single-outstanding bus,
// ties are broken by alternating against the last grant.
module cache_arbiter (
   input  logic            clk,
   input  logic            resetn,
   cache_arbiter_if.master bif
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   localparam logic GRANT_INST = 1'b0;
   localparam logic GRANT_DATA = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_ADDR = 3'd1,
      I_DATA = 3'd2,
      D_ADDR = 3'd3,
      D_DATA = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_wr_q, bus_wr_d;
   logic [SW-1:0] bus_wstrb_q, bus_wstrb_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic          grant_data_c;

   // data wins when it is alone, or on a tie when instruction was served last
   assign grant_data_c = bif.data_cache_req &
                         (~bif.inst_cache_req | (last_grant_q == GRANT_INST));

   // next-state and bus-register load logic
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      bus_req_d    = bus_req_q;
      bus_wr_d     = bus_wr_q;
      bus_wstrb_d  = bus_wstrb_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_data_c) begin
               state_d      = D_ADDR;
               last_grant_d = GRANT_DATA;
               bus_req_d    = 1'b1;
               bus_wr_d     = bif.data_cache_wr;
               bus_wstrb_d  = bif.data_cache_wr ? bif.data_cache_wstrb : SW'(0);
               bus_addr_d   = bif.data_cache_addr;
               bus_wdata_d  = bif.data_cache_wdata;
            end else if (bif.inst_cache_req) begin
               state_d      = I_ADDR;
               last_grant_d = GRANT_INST;
               bus_req_d    = 1'b1;
               bus_wr_d     = 1'b0;
               bus_wstrb_d  = SW'(0);
               bus_addr_d   = bif.inst_cache_addr;
               bus_wdata_d  = DW'(0);
            end
         end
         I_ADDR: begin
            if (bif.bus_addr_ok) begin
               state_d   = I_DATA;
               bus_req_d = 1'b0;
            end
         end
         D_ADDR: begin
            if (bif.bus_addr_ok) begin
               state_d   = D_DATA;
               bus_req_d = 1'b0;
            end
         end
         I_DATA, D_DATA: begin
            if (bif.bus_data_ok) state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // state and bus registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_INST;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_wstrb_q  <= SW'(0);
         bus_addr_q   <= AW'(0);
         bus_wdata_q  <= DW'(0);
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         bus_req_q    <= bus_req_d;
         bus_wr_q     <= bus_wr_d;
         bus_wstrb_q  <= bus_wstrb_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
      end
   end

   assign bif.bus_req   = bus_req_q;
   assign bif.bus_wr    = bus_wr_q;
   assign bif.bus_wstrb = bus_wstrb_q;
   assign bif.bus_addr  = bus_addr_q;
   assign bif.bus_wdata = bus_wdata_q;

   // completion is forwarded straight from the slave; suppressed while reset is asserted
   assign bif.inst_cache_dok   = resetn & (state_q == I_DATA) & bif.bus_data_ok;
   assign bif.data_cache_dok   = resetn & (state_q == D_DATA) & bif.bus_data_ok;
   assign bif.inst_cache_rdata = bif.bus_rdata;
   assign bif.data_cache_rdata = bif.bus_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random two-cache traffic against a
// transaction-level model and a word memory.
module tb_cache_arbiter;
   logic clk;
   logic resetn;
   cache_arbiter_if bif ();

   cache_arbiter dut (.clk(clk), .resetn(resetn), .bif(bif));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_on  = 1'b0;
   bit rand_on = 1'b0;

   logic [31:0] smem    [16];
   logic [31:0] ref_mem [16];
   int done_cnt [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // owner: 0 none, 1 inst, 2 data; acc: address phase done
   logic [1:0]  m_owner;
   logic        m_acc;
   logic        m_last_data;
   logic [31:0] m_addr, m_wdata;
   logic        m_wr;
   logic [3:0]  m_strb;

   always @(posedge clk) begin
      if (!resetn) begin
         m_owner <= 2'd0; m_acc <= 1'b0; m_last_data <= 1'b0;
         m_addr <= 32'h0; m_wdata <= 32'h0; m_wr <= 1'b0; m_strb <= 4'h0;
      end else if (m_owner == 2'd0) begin
         if (bif.data_cache_req && !(bif.inst_cache_req && m_last_data)) begin
            m_owner <= 2'd2; m_acc <= 1'b0; m_last_data <= 1'b1;
            m_addr <= bif.data_cache_addr; m_wr <= bif.data_cache_wr;
            m_strb <= bif.data_cache_wr ? bif.data_cache_wstrb : 4'h0;
            m_wdata <= bif.data_cache_wdata;
         end else if (bif.inst_cache_req) begin
            m_owner <= 2'd1; m_acc <= 1'b0; m_last_data <= 1'b0;
            m_addr <= bif.inst_cache_addr; m_wr <= 1'b0; m_strb <= 4'h0;
         end
      end else if (!m_acc) begin
         if (bif.bus_addr_ok) m_acc <= 1'b1;
      end else if (bif.bus_data_ok) begin
         m_owner <= 2'd0; m_acc <= 1'b0;
      end
   end

   // per-cycle comparison of every DUT output against the model
   initial forever begin
      @(negedge clk);
      #3;
      if (chk_on) begin
         logic ei, ed;
         ei = resetn && m_owner == 2'd1 && m_acc && bif.bus_data_ok;
         ed = resetn && m_owner == 2'd2 && m_acc && bif.bus_data_ok;
         chk("m_bus_req", 32'(bif.bus_req), 32'(m_owner != 2'd0 && !m_acc));
         chk("m_bus_addr", bif.bus_addr, m_addr);
         chk("m_bus_wr", 32'(bif.bus_wr), 32'(m_wr));
         chk("m_bus_wstrb", 32'(bif.bus_wstrb), 32'(m_strb));
         if (m_wr) chk("m_bus_wdata", bif.bus_wdata, m_wdata);
         chk("m_inst_dok", 32'(bif.inst_cache_dok), 32'(ei));
         chk("m_data_dok", 32'(bif.data_cache_dok), 32'(ed));
         if (ei) chk("m_inst_rdata", bif.inst_cache_rdata, bif.bus_rdata);
         if (ed) chk("m_data_rdata", bif.data_cache_rdata, bif.bus_rdata);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_txn(input string nm, input bit is_data, input logic [31:0] ea, input bit ew,
                         input logic [3:0] es, input logic [31:0] ed, input int adly, input int ddly,
                         input logic [31:0] rd, input bit scr, input bit drop);
      int n = 0;
      @(negedge clk);
      while (bif.bus_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk({nm, "_grant"}, 32'(bif.bus_req), 32'h1);
      chk({nm, "_addr"}, bif.bus_addr, ea);
      chk({nm, "_wr"}, 32'(bif.bus_wr), 32'(ew));
      chk({nm, "_wstrb"}, 32'(bif.bus_wstrb), 32'(es));
      if (ew) chk({nm, "_wdata"}, bif.bus_wdata, ed);
      if (drop) begin
         if (is_data) bif.data_cache_req = 1'b0; else bif.inst_cache_req = 1'b0;
      end
      repeat (adly) begin
         if (scr) begin
            bif.data_cache_addr  = $urandom;
            bif.data_cache_wdata = $urandom;
            bif.bus_data_ok      = 1'b1;
         end
         @(negedge clk);
         #1;
         chk({nm, "_hold_addr"}, bif.bus_addr, ea);
         chk({nm, "_hold_req"}, 32'(bif.bus_req), 32'h1);
         chk({nm, "_early_dok"}, 32'(bif.inst_cache_dok | bif.data_cache_dok), 32'h0);
      end
      bif.bus_data_ok = 1'b0;
      bif.bus_addr_ok = 1'b1;
      @(negedge clk);
      bif.bus_addr_ok = 1'b0;
      chk({nm, "_req_drop"}, 32'(bif.bus_req), 32'h0);
      repeat (ddly) begin
         @(negedge clk);
         chk({nm, "_wait_dok"}, 32'(bif.inst_cache_dok | bif.data_cache_dok), 32'h0);
      end
      bif.bus_data_ok = 1'b1;
      bif.bus_rdata   = rd;
      #1;
      chk({nm, "_dok"}, 32'(is_data ? bif.data_cache_dok : bif.inst_cache_dok), 32'h1);
      chk({nm, "_other_dok"}, 32'(is_data ? bif.inst_cache_dok : bif.data_cache_dok), 32'h0);
      chk({nm, "_rdata"}, is_data ? bif.data_cache_rdata : bif.inst_cache_rdata, rd);
      @(negedge clk);
      bif.bus_data_ok = 1'b0;
      if (is_data) bif.data_cache_req = 1'b0; else bif.inst_cache_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // ---------------- random agents ----------------
   task automatic requester(input bit is_data, input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] a, wd;
         logic [3:0]  st;
         logic        w;
         int          cyc;
         bit          got;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         #1;
         a   = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
         w   = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
         st  = 4'($urandom);
         wd  = $urandom;
         if (is_data) begin
            bif.data_cache_addr = a; bif.data_cache_wr = w;
            bif.data_cache_wstrb = st; bif.data_cache_wdata = wd;
            bif.data_cache_req = 1'b1;
         end else begin
            bif.inst_cache_addr = a;
            bif.inst_cache_req  = 1'b1;
         end
         cyc = 0; got = 1'b0;
         while (!got && cyc < 300) begin
            @(negedge clk);
            #3;
            if (is_data ? bif.data_cache_dok : bif.inst_cache_dok) got = 1'b1; else cyc++;
         end
         chk(is_data ? "r_data_done" : "r_inst_done", 32'(got), 32'h1);
         if (got) begin
            done_cnt[is_data]++;
            if (!w)
               chk(is_data ? "r_data_rdata" : "r_inst_rdata",
                   is_data ? bif.data_cache_rdata : bif.inst_cache_rdata, ref_mem[a[5:2]]);
            else
               for (int b = 0; b < 4; b++)
                  if (st[b]) ref_mem[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
         end
         if (is_data) bif.data_cache_req = 1'b0; else bif.inst_cache_req = 1'b0;
      end
   endtask

   task automatic slave_loop();
      while (rand_on) begin
         @(negedge clk);
         #1;
         if (bif.bus_req === 1'b1) begin
            logic [31:0] a, wd;
            logic [3:0]  st;
            logic        w;
            a = bif.bus_addr; w = bif.bus_wr; st = bif.bus_wstrb; wd = bif.bus_wdata;
            repeat ($urandom_range(0, 3)) begin
               bif.bus_data_ok = 1'($urandom_range(0, 1));
               @(negedge clk);
               #1;
            end
            bif.bus_data_ok = 1'b0;
            bif.bus_addr_ok = 1'b1;
            @(negedge clk);
            #1;
            bif.bus_addr_ok = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               bif.bus_addr_ok = 1'($urandom_range(0, 1));
               @(negedge clk);
               #1;
            end
            bif.bus_addr_ok = 1'b0;
            if (w) begin
               for (int b = 0; b < 4; b++)
                  if (st[b]) smem[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
               bif.bus_rdata = $urandom;
            end else begin
               bif.bus_rdata = smem[a[5:2]];
            end
            bif.bus_data_ok = 1'b1;
            @(negedge clk);
            #1;
            bif.bus_data_ok = 1'b0;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      resetn = 1'b0;
      bif.inst_cache_req = 1'b0; bif.inst_cache_addr = 32'h0;
      bif.data_cache_req = 1'b0; bif.data_cache_wr = 1'b0; bif.data_cache_wstrb = 4'h0;
      bif.data_cache_addr = 32'h0; bif.data_cache_wdata = 32'h0;
      bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = 32'h0;
      for (int i = 0; i < 16; i++) begin
         smem[i]    = 32'h1111_1111 * 32'(i);
         ref_mem[i] = 32'h1111_1111 * 32'(i);
      end
      done_cnt[0] = 0; done_cnt[1] = 0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      chk("rst_bus_req", 32'(bif.bus_req), 32'h0);
      chk("rst_bus_addr", bif.bus_addr, 32'h0);
      chk("rst_bus_wdata", bif.bus_wdata, 32'h0);
      chk("rst_bus_wstrb", 32'(bif.bus_wstrb), 32'h0);
      chk("rst_bus_wr", 32'(bif.bus_wr), 32'h0);
      chk("rst_doks", 32'(bif.inst_cache_dok | bif.data_cache_dok), 32'h0);
      resetn = 1'b1;

      // instruction fetch, immediate addr_ok, data 3 cycles after accept
      bif.inst_cache_addr = 32'hBFC0_0000; bif.inst_cache_req = 1'b1;
      do_txn("ifetch", 1'b0, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 0, 2, 32'h2408_0001, 1'b0, 1'b0);

      // data write with partial strobes
      bif.data_cache_addr = 32'h8000_1000; bif.data_cache_wdata = 32'hDEAD_BEEF;
      bif.data_cache_wstrb = 4'b0011; bif.data_cache_wr = 1'b1; bif.data_cache_req = 1'b1;
      do_txn("dwrite", 1'b1, 32'h8000_1000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1, 0, 32'h0, 1'b0, 1'b0);

      // tie after reset goes to data, then inst, then data again
      do_reset();
      bif.inst_cache_addr = 32'hBFC0_0010; bif.inst_cache_req = 1'b1;
      bif.data_cache_addr = 32'h8000_0020; bif.data_cache_wr = 1'b0;
      bif.data_cache_wstrb = 4'hF; bif.data_cache_req = 1'b1;
      do_txn("tie1_data", 1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 1'b0);
      do_txn("tie1_inst", 1'b0, 32'hBFC0_0010, 1'b0, 4'h0, 32'h0, 0, 1, 32'h0000_0013, 1'b0, 1'b0);
      bif.inst_cache_req = 1'b1; bif.data_cache_req = 1'b1;
      do_txn("tie2_data", 1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0, 2, 0, 32'hCAFE_0001, 1'b0, 1'b0);
      do_txn("tie2_inst", 1'b0, 32'hBFC0_0010, 1'b0, 4'h0, 32'h0, 0, 0, 32'hCAFE_0002, 1'b0, 1'b0);

      // slow slave, requester scribbles inputs and drops its request after grant
      bif.data_cache_addr = 32'h8000_0444; bif.data_cache_wr = 1'b1;
      bif.data_cache_wstrb = 4'b1100; bif.data_cache_wdata = 32'h5555_AAAA; bif.data_cache_req = 1'b1;
      do_txn("slow_wr", 1'b1, 32'h8000_0444, 1'b1, 4'b1100, 32'h5555_AAAA, 5, 1, 32'h0, 1'b1, 1'b1);

      // reset during the instruction data phase
      begin
         int n = 0;
         bif.inst_cache_addr = 32'hBFC0_0040; bif.inst_cache_req = 1'b1;
         @(negedge clk);
         while (bif.bus_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         chk("rstmid_grant", 32'(bif.bus_req), 32'h1);
         bif.bus_addr_ok = 1'b1;
         @(negedge clk);
         bif.bus_addr_ok = 1'b0;
         resetn = 1'b0;
         bif.bus_data_ok = 1'b1;
         bif.bus_rdata = 32'hFFFF_0000;
         #1;
         chk("rstmid_dok_in_rst", 32'(bif.inst_cache_dok), 32'h0);
         @(negedge clk);
         chk("rstmid_bus_req", 32'(bif.bus_req), 32'h0);
         chk("rstmid_bus_addr", bif.bus_addr, 32'h0);
         chk("rstmid_dok_after", 32'(bif.inst_cache_dok | bif.data_cache_dok), 32'h0);
         bif.inst_cache_req = 1'b0;
         bif.bus_data_ok = 1'b0;
         resetn = 1'b1;
         @(negedge clk);
         chk("rstmid_idle", 32'(bif.bus_req), 32'h0);
      end

      // random back-to-back traffic against a random-latency slave
      rand_on = 1'b1;
      fork
         begin
            fork
               requester(1'b0, 60);
               requester(1'b1, 60);
            join
            rand_on = 1'b0;
         end
         slave_loop();
      join
      chk("inst_done_count", 32'(done_cnt[0]), 32'd60);
      chk("data_done_count", 32'(done_cnt[1]), 32'd60);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // runaway guard
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
